// File: rtl/seg7_reader_if.sv
// Segment inputs and decoded outputs of the 7-segment reader, bundled for port use.
interface seg7_reader_if;
    // Segment lines, active-high, asynchronous to the reader clock.
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       e;
    logic       f;
    logic       g;

    // Decoded results.
    logic [2:0] value;
    logic       valid;
    logic       err;
    logic       blank;
    logic [7:0] count;

    // Display side: drives segments, observes results.
    modport master (
        output a, b, c, d, e, f, g,
        input  value, valid, err, blank, count
    );

    // Reader side: samples segments, produces results.
    modport slave (
        input  a, b, c, d, e, f, g,
        output value, valid, err, blank, count
    );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: synchronizes a 7-segment pattern, waits for it to hold steady and
// decodes it to a digit 0..7, flagging illegal patterns and an all-off display.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic          clk,
    input logic          rst_n,
    seg7_reader_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StReport
    } state_e;

    localparam logic [3:0] CntMax    = 4'(STABLE_CYCLES);
    // Entering StReport takes one more edge, so accept one count early.
    localparam logic [3:0] CntAccept = 4'(STABLE_CYCLES - 1);

    logic [6:0] seg_in;
    logic [6:0] sync1_q;
    logic [6:0] pat_q;
    logic       pat_change;
    logic [3:0] cnt_q;

    state_e     state_q, state_d;
    logic       accept;

    logic       pat_legal;
    logic [2:0] pat_digit;

    logic [6:0] last_q, last_d;
    logic [2:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       blank_q, blank_d;
    logic [7:0] count_q, count_d;

    assign seg_in = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

    // Two-flop synchronizer; pat_q is the pattern P seen by the rest of the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 7'd0;
            pat_q   <= 7'd0;
        end else begin
            sync1_q <= seg_in;
            pat_q   <= sync1_q;
        end
    end

    // P takes a new value on the coming edge.
    assign pat_change = (sync1_q != pat_q);

    // Stability counter: clocks P has held its current value, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (pat_change) begin
            cnt_q <= 4'd0;
        end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Legal digit table, bit order abcdefg.
    always_comb begin
        pat_legal = 1'b1;
        pat_digit = 3'd0;
        case (pat_q)
            7'b1111110: pat_digit = 3'd0;
            7'b0110000: pat_digit = 3'd1;
            7'b1101101: pat_digit = 3'd2;
            7'b1111001: pat_digit = 3'd3;
            7'b0110011: pat_digit = 3'd4;
            7'b1011011: pat_digit = 3'd5;
            7'b1011111: pat_digit = 3'd6;
            7'b1110000: pat_digit = 3'd7;
            default:    pat_legal = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; accept marks the edge that enters StReport.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pat_q != last_q) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (pat_q == last_q) begin
                    state_d = StIdle;
                end else if (cnt_q >= CntAccept) begin
                    state_d = StReport;
                    accept  = 1'b1;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Acceptance results are registered on entry to StReport so the pulses
    // occupy exactly the single StReport cycle.
    always_comb begin
        last_d  = last_q;
        value_d = value_q;
        count_d = count_q;
        blank_d = blank_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            last_d  = pat_q;
            blank_d = (pat_q == 7'd0);
            if (pat_legal) begin
                value_d = pat_digit;
                valid_d = 1'b1;
                count_d = count_q + 8'd1;
            end else if (pat_q != 7'd0) begin
                err_d = 1'b1;
            end
        end
    end

    // Output and last-accepted-pattern registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 7'd0;
            value_q <= 3'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            blank_q <= 1'b1;
            count_q <= 8'd0;
        end else begin
            last_q  <= last_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            blank_q <= blank_d;
            count_q <= count_d;
        end
    end

    assign bus.value = value_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.blank = blank_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: expected pulses are queued when a pattern is driven and
// matched (kind, value, count, blank, arrival cycle) when the DUT pulses.
module tb_seg7_reader;

    localparam int unsigned S = 4;

    typedef struct packed {
        logic [1:0]  kind;   // {valid, err}
        logic [2:0]  value;
        logic [7:0]  count;
        logic        blank;
        logic [31:0] cyc;
    } evt_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] cyc;
    int          total;
    int          bad;

    logic [6:0]  seg_tab [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};

    // Reference model state.
    logic [6:0]  m_last;
    logic [2:0]  m_value;
    logic [7:0]  m_count;
    logic        m_blank;
    evt_t        exp_q [$];

    seg7_reader_if bus ();

    seg7_reader #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 32'd0;
        forever begin
            @(posedge clk);
            cyc = cyc + 32'd1;
        end
    end

    // Scoreboard: every pulse pops one expectation.
    initial begin
        evt_t o;
        evt_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.valid || bus.err)) begin
                o = '{{bus.valid, bus.err}, bus.value, bus.count, bus.blank, cyc};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: got kind=%b value=%0d count=%0d cyc=%0d, required no pulse",
                             o.kind, o.value, o.count, o.cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        bad++;
                        $display("FAIL pulse: got kind=%b value=%0d count=%0d blank=%b cyc=%0d, required kind=%b value=%0d count=%0d blank=%b cyc=%0d",
                                 o.kind, o.value, o.count, o.blank, o.cyc,
                                 e.kind, e.value, e.count, e.blank, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

    task automatic set_seg(input logic [6:0] p);
        {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = p;
    endtask

    task automatic model_reset();
        m_last  = 7'd0;
        m_value = 3'd0;
        m_count = 8'd0;
        m_blank = 1'b1;
    endtask

    // Drive pat for hold clocks; long holds of a new pattern queue the expected outcome.
    task automatic present(input logic [6:0] pat, input int hold);
        int          d;
        logic [31:0] c;
        @(negedge clk);
        set_seg(pat);
        c = cyc;
        if (hold >= int'(S) + 2 && pat != m_last) begin
            d = -1;
            for (int i = 0; i < 8; i++) begin
                if (seg_tab[i] == pat) d = i;
            end
            m_last = pat;
            if (d >= 0) begin
                m_value = 3'(d);
                m_count = m_count + 8'd1;
                m_blank = 1'b0;
                exp_q.push_back('{2'b10, m_value, m_count, 1'b0, c + 32'd2 + 32'(S)});
            end else if (pat == 7'd0) begin
                m_blank = 1'b1;
            end else begin
                m_blank = 1'b0;
                exp_q.push_back('{2'b01, m_value, m_count, 1'b0, c + 32'd2 + 32'(S)});
            end
        end
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] c;
        rst_n = 1'b0;
        set_seg(7'b0110000);
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.value, bus.valid, bus.err, bus.blank, bus.count} !== {3'd0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL reset_values: got value=%0d valid=%b err=%b blank=%b count=%0d, required 0 0 0 1 0",
                     bus.value, bus.valid, bus.err, bus.blank, bus.count);
        end
        // Release between edges; the next rising edge is edge 0, pulse due after edge 5.
        rst_n = 1'b1;
        c = cyc;
        m_last  = 7'b0110000;
        m_value = 3'd1;
        m_count = 8'd1;
        m_blank = 1'b0;
        exp_q.push_back('{2'b10, 3'd1, 8'd1, 1'b0, c + 32'd2 + 32'(S)});
        repeat (10) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_release_pulse: got %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if ({bus.value, bus.count, bus.blank} !== {3'd1, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL reset_release_state: got value=%0d count=%0d blank=%b, required 1 1 0",
                     bus.value, bus.count, bus.blank);
        end
    endtask

    task automatic test_digits();
        logic [7:0] start;
        start = m_count;
        for (int i = 0; i < 8; i++) present(seg_tab[i], 10);
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL digits_pulses: got %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if ({bus.value, bus.count} !== {3'd7, start + 8'd8}) begin
            bad++;
            $display("FAIL digits_state: got value=%0d count=%0d, required 7 %0d",
                     bus.value, bus.count, start + 8'd8);
        end
    endtask

    task automatic test_glitch();
        present(seg_tab[3], 10);
        present(7'b1111111, 2);
        present(seg_tab[3], 10);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_pulses: got %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if ({bus.value, bus.count} !== {3'd3, m_count}) begin
            bad++;
            $display("FAIL glitch_state: got value=%0d count=%0d, required 3 %0d",
                     bus.value, bus.count, m_count);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] start;
        start = m_count;
        present(7'b1111111, 10);
        total++;
        if ({bus.value, bus.count, bus.blank} !== {3'd3, start, 1'b0}) begin
            bad++;
            $display("FAIL illegal_state: got value=%0d count=%0d blank=%b, required 3 %0d 0",
                     bus.value, bus.count, bus.blank, start);
        end
        present(7'b0000000, 10);
        total++;
        if ({bus.value, bus.count, bus.blank} !== {3'd3, start, 1'b1}) begin
            bad++;
            $display("FAIL blank_state: got value=%0d count=%0d blank=%b, required 3 %0d 1",
                     bus.value, bus.count, bus.blank, start);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL illegal_pulses: got %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_wrap();
        int n;
        n = 256 - int'(m_count);
        for (int i = 0; i < n; i++) present((i % 2 == 0) ? seg_tab[0] : seg_tab[1], 7);
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_pulses: got %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if ({bus.count, bus.value, bus.blank} !== {8'd0, m_value, 1'b0}) begin
            bad++;
            $display("FAIL wrap_state: got count=%0d value=%0d blank=%b, required 0 %0d 0",
                     bus.count, bus.value, bus.blank, m_value);
        end
    endtask

    task automatic test_reset_mid_settle();
        @(negedge clk);
        set_seg(seg_tab[5]);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        set_seg(7'b0000000);
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.value, bus.valid, bus.err, bus.blank, bus.count} !== {3'd0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL mid_settle_reset: got value=%0d valid=%b err=%b blank=%b count=%0d, required 0 0 0 1 0",
                     bus.value, bus.valid, bus.err, bus.blank, bus.count);
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if ({bus.value, bus.valid, bus.err, bus.blank, bus.count} !== {3'd0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL mid_settle_after: got value=%0d valid=%b err=%b blank=%b count=%0d, required 0 0 0 1 0",
                     bus.value, bus.valid, bus.err, bus.blank, bus.count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_seg(7'b0000000);
        model_reset();
        test_reset();
        test_digits();
        test_glitch();
        test_illegal();
        test_wrap();
        test_reset_mid_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive clocks a synchronized pattern must hold before it is accepted (legal range 2..15).
REQ-002 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; assertion takes effect immediately, release is synchronous to clk.
REQ-004 a, b, c, d, e, f, g  input  1 each  segment lines, active-high, asynchronous to clk.
REQ-005 value  output  3  last accepted digit 0..7.
REQ-006 valid  output  1  one-cycle pulse when value is updated.
REQ-007 err  output  1  one-cycle pulse when a stable illegal pattern is accepted.
REQ-008 blank  output  1  level, high while the last accepted pattern is all-off.
REQ-009 count  output  8  number of valid pulses since reset, wraps 255 -> 0.

Function
REQ-010 Segment inputs SHALL pass through a 2-flop synchronizer, giving pattern P = {a,b,c,d,e,f,g}.
REQ-011 Legal table SHALL be (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
REQ-012 The stability counter SHALL clear on any clock where P differs from its previous value; otherwise it SHALL increment, saturating at STABLE_CYCLES.
REQ-013 FSM states: IDLE (P equals last accepted pattern L), SETTLE (P differs from L, counting), REPORT (single-cycle acceptance).
REQ-014 IDLE -> SETTLE when P != L; SETTLE -> IDLE if P returns to L before the count reaches STABLE_CYCLES; SETTLE -> REPORT when P has held for STABLE_CYCLES clocks; REPORT -> IDLE unconditionally.
REQ-015 In REPORT: L <= P; legal P -> value updated, valid=1, count+1; all-zero P -> blank=1, no valid/err; other P -> err=1, value and count unchanged.
REQ-016 blank SHALL clear on the REPORT of any non-zero pattern.
REQ-017 valid and err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per acceptance.
REQ-018 Latency: inputs changing to a new constant pattern before edge k SHALL produce the valid/err/blank update at edge k+1+STABLE_CYCLES.
REQ-019 Re-presenting the same pattern as L (including after glitches shorter than STABLE_CYCLES) SHALL produce no pulse.
REQ-020 A change of P during REPORT SHALL be ignored in that cycle and evaluated in IDLE on the next cycle.
REQ-021 count SHALL wrap from 255 to 0 on the 256th valid without any other side effect.

Reset
REQ-022 While rst_n=0: value=0, valid=0, err=0, blank=1, count=0, L=0000000, synchronizer and stability counter cleared, state IDLE.
REQ-023 Reset asserted mid-SETTLE or mid-REPORT SHALL abort the acceptance with no pulse emitted.
REQ-024 After release, a pattern held on the inputs throughout reset SHALL be accepted normally per REQ-018 if it differs from 0000000.

Verification
REQ-025 Reset release with 0110000 held -> valid at edge 5 after release (STABLE_CYCLES=4), value=1, count=1, blank=0.
REQ-026 Step through digits 0..7, each held 10 clocks -> 8 valid pulses, value follows 0..7, count=8, err never high.
REQ-027 On value 3, 2-cycle glitch to 1111111, then back to 1111001 -> no valid, no err, value stays 3.
REQ-028 Hold 1111111 for 10 clocks -> one err pulse, value unchanged, count unchanged; then 0000000 -> blank=1, no pulse.
REQ-029 Alternate 1111110/0110000 for 256 acceptances -> count wraps to 0; rst_n pulsed low mid-SETTLE -> no pulse, all outputs at REQ-022 values.
